// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 byte-to-code-point decoder with a record FIFO on the output.
// Optional build macro UTF8_PROPS_EN adds per-record character-property flags (out_props).
module utf8_stream_decoder #(
    parameter int unsigned MAX_LEN    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        chk_range,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [31:0] out_cp,
    output logic [4:0]  out_err,
`ifdef UTF8_PROPS_EN
    output logic [4:0]  out_props,
`endif
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] ERR_RETRY   = 5'b10001;
    localparam logic [4:0] ERR_INVALID = 5'b10010;

    typedef enum logic [1:0] {IDLE, CONT, REPLAY} state_t;

    state_t      state, n_state;
    logic [2:0]  need, n_need, len, n_len;
    logic [30:0] cp, n_cp, acc;
    logic [7:0]  hold_byte, n_hold, cur;
    logic        flush_pending, n_fpend;
    logic        proc, push, pop, full, ovl, nu;
    logic [30:0] push_cp;
    logic [4:0]  push_err;

    logic [30:0] mem_cp  [FIFO_DEPTH];
    logic [4:0]  mem_err [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    function automatic logic [30:0] min_cp(input logic [2:0] l);
        case (l)
            3'd2:    min_cp = 31'h80;
            3'd3:    min_cp = 31'h800;
            3'd4:    min_cp = 31'h10000;
            3'd5:    min_cp = 31'h200000;
            default: min_cp = 31'h4000000;
        endcase
    endfunction

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign in_ready  = !full && (state != REPLAY);
    assign out_cp    = out_valid ? {1'b0, mem_cp[rd_ptr]} : '0;
    assign out_err   = out_valid ? mem_err[rd_ptr] : '0;

    always_comb begin
        n_state  = state;
        n_need   = need;
        n_len    = len;
        n_cp     = cp;
        n_hold   = hold_byte;
        n_fpend  = flush_pending;
        push     = 1'b0;
        push_cp  = '0;
        push_err = '0;
        acc      = '0;
        ovl      = 1'b0;
        nu       = 1'b0;
        cur      = (state == REPLAY) ? hold_byte : in_data;
        // A held byte only replays once its possible record has a free slot.
        proc     = (state == REPLAY) ? !full : (in_valid && in_ready);

        if (proc) begin
            if (state == CONT) begin
                if (cur[7:6] == 2'b10) begin
                    acc    = {cp[24:0], cur[5:0]};
                    n_cp   = acc;
                    n_need = need - 3'd1;
                    if (need == 3'd1) begin
                        ovl      = (acc < min_cp(len));
                        nu       = chk_range && (acc > 31'h10FFFF);
                        push     = 1'b1;
                        push_cp  = acc;
                        push_err = {ovl | nu, nu, ovl, 1'b0, 1'b0};
                        n_state  = IDLE;
                    end
                end else begin
                    push     = 1'b1;
                    push_cp  = cp;
                    push_err = ERR_RETRY;
                    n_hold   = cur;
                    n_state  = REPLAY;
                end
            end else begin
                n_state = IDLE;
                if (cur[7] == 1'b0) begin
                    push    = 1'b1;
                    push_cp = {23'd0, cur};
                end else if (cur[7:5] == 3'b110) begin
                    n_cp = {26'd0, cur[4:0]}; n_len = 3'd2; n_need = 3'd1; n_state = CONT;
                end else if (cur[7:4] == 4'b1110) begin
                    n_cp = {27'd0, cur[3:0]}; n_len = 3'd3; n_need = 3'd2; n_state = CONT;
                end else if (cur[7:3] == 5'b11110) begin
                    n_cp = {28'd0, cur[2:0]}; n_len = 3'd4; n_need = 3'd3; n_state = CONT;
                end else if (MAX_LEN == 6 && cur[7:2] == 6'b111110) begin
                    n_cp = {29'd0, cur[1:0]}; n_len = 3'd5; n_need = 3'd4; n_state = CONT;
                end else if (MAX_LEN == 6 && cur[7:1] == 7'b1111110) begin
                    n_cp = {30'd0, cur[0]};   n_len = 3'd6; n_need = 3'd5; n_state = CONT;
                end else begin
                    push     = 1'b1;
                    push_cp  = {23'd0, cur};
                    push_err = ERR_INVALID;
                end
            end
        end

        // Flush acts on the post-byte state; it waits if this cycle's slot is taken or a replay is due.
        if (flush || flush_pending) begin
            if (n_state == CONT) begin
                if (!push && !full) begin
                    push     = 1'b1;
                    push_cp  = n_cp;
                    push_err = ERR_INVALID;
                    n_state  = IDLE;
                    n_fpend  = 1'b0;
                end else begin
                    n_fpend = 1'b1;
                end
            end else if (n_state == REPLAY) begin
                n_fpend = 1'b1;
            end else begin
                n_fpend = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            need          <= '0;
            len           <= '0;
            cp            <= '0;
            hold_byte     <= '0;
            flush_pending <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            state         <= n_state;
            need          <= n_need;
            len           <= n_len;
            cp            <= n_cp;
            hold_byte     <= n_hold;
            flush_pending <= n_fpend;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_cp[wr_ptr]  <= push_cp;
            mem_err[wr_ptr] <= push_err;
        end
    end

`ifdef UTF8_PROPS_EN
    logic [4:0] mem_props [FIFO_DEPTH];

    function automatic logic [4:0] props_of(input logic [30:0] c);
        logic ctl, sur, hi, prv, nch;
        ctl = (c < 31'h20) || (c >= 31'h7F && c <= 31'h9F);
        sur = (c >= 31'hD800) && (c <= 31'hDFFF);
        hi  = (c > 31'h10FFFF);
        prv = (c >= 31'hE000 && c <= 31'hF8FF) || (c >= 31'hF0000 && c <= 31'hFFFFD) ||
              (c >= 31'h100000 && c <= 31'h10FFFD);
        nch = (c >= 31'hFDD0 && c <= 31'hFDEF) || (c[15:0] >= 16'hFFFE && !hi);
        props_of = {nch, prv, hi, sur, ctl};
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem_props[wr_ptr] <= props_of(push_cp);
    end

    assign out_props = out_valid ? mem_props[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Directed self-checking bench for utf8_stream_decoder (MAX_LEN=4 and MAX_LEN=6 instances).
module tb_utf8_stream_decoder;

    logic        clk = 1'b0;
    logic        rst, chk_range, in_valid, in_ready, flush, out_valid, out_ready;
    logic [7:0]  in_data;
    logic [31:0] out_cp;
    logic [4:0]  out_err;
    logic        chk6, in_valid6, in_ready6, flush6, out_valid6, out_ready6;
    logic [7:0]  in_data6;
    logic [31:0] out_cp6;
    logic [4:0]  out_err6;
`ifdef UTF8_PROPS_EN
    logic [4:0]  out_props, out_props6;
`endif

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [36:0] rec_q[$];
    logic [36:0] rec6_q[$];

    always #5 clk = ~clk;

    utf8_stream_decoder #(.MAX_LEN(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .chk_range(chk_range), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_cp(out_cp), .out_err(out_err),
`ifdef UTF8_PROPS_EN
        .out_props(out_props),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    utf8_stream_decoder #(.MAX_LEN(6), .FIFO_DEPTH(4)) dut6 (
        .clk(clk), .rst(rst), .chk_range(chk6), .in_data(in_data6),
        .in_valid(in_valid6), .in_ready(in_ready6), .flush(flush6),
        .out_cp(out_cp6), .out_err(out_err6),
`ifdef UTF8_PROPS_EN
        .out_props(out_props6),
`endif
        .out_valid(out_valid6), .out_ready(out_ready6)
    );

    // Records are captured on the falling edge, the cycle before the pop edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) rec_q.push_back({out_cp, out_err});
        if (!rst && out_valid6 && out_ready6) rec6_q.push_back({out_cp6, out_err6});
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int unsigned n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL send_timeout byte=%h in_ready stayed 0, required 1", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send6(input logic [7:0] b);
        int unsigned n = 0;
        in_data6 = b;
        in_valid6 = 1'b1;
        while (!in_ready6 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL send6_timeout byte=%h in_ready stayed 0, required 1", b);
        end
        @(posedge clk); #1;
        in_valid6 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_cp !== 32'h0) begin failures++; $display("FAIL reset_out_cp got=%h exp=0", out_cp); end
        checks++; if (out_err !== 5'h0) begin failures++; $display("FAIL reset_out_err got=%h exp=0", out_err); end
    endtask

    task automatic test_multibyte;
        logic [7:0]  bytes [10];
        logic [36:0] exp [4];
        bytes = '{8'h41, 8'hC3, 8'hA9, 8'hE2, 8'h82, 8'hAC, 8'hF0, 8'h9F, 8'h98, 8'h80};
        exp = '{{32'h41, 5'h0}, {32'hE9, 5'h0}, {32'h20AC, 5'h0}, {32'h1F600, 5'h0}};
        rec_q.delete();
        for (int i = 0; i < 10; i++) send(bytes[i]);
        idle(4);
        checks++;
        if (rec_q.size() != 4) begin failures++; $display("FAIL multibyte_count got=%0d exp=4", rec_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rec_q.size() <= i || rec_q[i] !== exp[i]) begin
                failures++;
                $display("FAIL multibyte_rec%0d got=%h exp=%h", i, (rec_q.size() > i) ? rec_q[i] : 37'h0, exp[i]);
            end
        end
    endtask

    task automatic test_overlong_range;
        rec_q.delete();
        chk_range = 1'b1;
        send(8'hC0); send(8'h80);
        send(8'hF4); send(8'h90); send(8'h80); send(8'h80);
        idle(3);
        chk_range = 1'b0;
        send(8'hF4); send(8'h90); send(8'h80); send(8'h80);
        idle(4);
        checks++;
        if (rec_q.size() != 3) begin failures++; $display("FAIL range_count got=%0d exp=3", rec_q.size()); end
        else begin
            checks++; if (rec_q[0] !== {32'h0, 5'h14}) begin failures++; $display("FAIL overlong_c080 got=%h exp=%h", rec_q[0], {32'h0, 5'h14}); end
            checks++; if (rec_q[1] !== {32'h110000, 5'h18}) begin failures++; $display("FAIL nonuni_on got=%h exp=%h", rec_q[1], {32'h110000, 5'h18}); end
            checks++; if (rec_q[2] !== {32'h110000, 5'h0}) begin failures++; $display("FAIL nonuni_off got=%h exp=%h", rec_q[2], {32'h110000, 5'h0}); end
        end
    endtask

    task automatic test_retry;
        rec_q.delete();
        send(8'hE2);
        send(8'h41);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL retry_bubble got=%b exp=0", in_ready); end
        idle(1);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL retry_ready_back got=%b exp=1", in_ready); end
        idle(3);
        checks++;
        if (rec_q.size() != 2) begin failures++; $display("FAIL retry_count got=%0d exp=2", rec_q.size()); end
        else begin
            checks++; if (rec_q[0] !== {32'h2, 5'h11}) begin failures++; $display("FAIL retry_rec got=%h exp=%h", rec_q[0], {32'h2, 5'h11}); end
            checks++; if (rec_q[1] !== {32'h41, 5'h0}) begin failures++; $display("FAIL retry_replay got=%h exp=%h", rec_q[1], {32'h41, 5'h0}); end
        end
    endtask

    task automatic test_invalid;
        rec_q.delete();
        send(8'h80);
        send(8'hFF);
        idle(3);
        checks++;
        if (rec_q.size() != 2) begin failures++; $display("FAIL invalid_count got=%0d exp=2", rec_q.size()); end
        else begin
            checks++; if (rec_q[0] !== {32'h80, 5'h12}) begin failures++; $display("FAIL invalid_80 got=%h exp=%h", rec_q[0], {32'h80, 5'h12}); end
            checks++; if (rec_q[1] !== {32'hFF, 5'h12}) begin failures++; $display("FAIL invalid_ff got=%h exp=%h", rec_q[1], {32'hFF, 5'h12}); end
        end
    endtask

    task automatic test_six_byte_mode;
        rec6_q.delete();
        send6(8'hF8); send6(8'h88); send6(8'h80); send6(8'h80); send6(8'h80);
        idle(3);
        checks++;
        if (rec6_q.size() != 1) begin failures++; $display("FAIL len5_count got=%0d exp=1", rec6_q.size()); end
        else begin
            checks++; if (rec6_q[0] !== {32'h200000, 5'h0}) begin failures++; $display("FAIL len5_rec got=%h exp=%h", rec6_q[0], {32'h200000, 5'h0}); end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp [5];
        exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        rec_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(exp[i]);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        in_data = exp[4];
        in_valid = 1'b1;
        idle(2);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_hold got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL after_pop_ready got=%b exp=1", in_ready); end
        idle(1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(8);
        checks++;
        if (rec_q.size() != 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", rec_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rec_q.size() <= i || rec_q[i] !== {24'h0, exp[i], 5'h0}) begin
                failures++;
                $display("FAIL bp_order%0d got=%h exp=%h", i, (rec_q.size() > i) ? rec_q[i] : 37'h0, {24'h0, exp[i], 5'h0});
            end
        end
    endtask

    task automatic test_flush;
        rec_q.delete();
        send(8'hE2);
        send(8'h82);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(3);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(3);
        checks++;
        if (rec_q.size() != 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", rec_q.size()); end
        else begin
            checks++; if (rec_q[0] !== {32'h82, 5'h12}) begin failures++; $display("FAIL flush_rec got=%h exp=%h", rec_q[0], {32'h82, 5'h12}); end
        end
    endtask

    task automatic test_reset_mid;
        rec_q.delete();
        out_ready = 1'b0;
        send(8'h41);
        send(8'hE2);
        send(8'h82);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        send(8'h5A);
        idle(4);
        checks++;
        if (rec_q.size() != 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", rec_q.size()); end
        else begin
            checks++; if (rec_q[0] !== {32'h5A, 5'h0}) begin failures++; $display("FAIL midrst_rec got=%h exp=%h", rec_q[0], {32'h5A, 5'h0}); end
        end
    endtask

    initial begin
        rst = 1'b1; chk_range = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        chk6 = 1'b0; in_data6 = '0; in_valid6 = 1'b0; flush6 = 1'b0; out_ready6 = 1'b1;
        #1;
        test_reset;
        test_multibyte;
        test_overlong_range;
        test_retry;
        test_invalid;
        test_six_byte_mode;
        test_backpressure;
        test_flush;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
